instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Responder side of the control unit's fetch handshake. Accepts a fetch request (`fetch_en`, `fetch_address`), issues one read to instruction memory over a valid/ready request channel with a separate response channel, and returns the 32-bit instruction with a one-cycle `fetch_done` pulse. Misaligned addresses are trapped locally, and memory stalls are bounded by a timeout. Sits between the control unit and the instruction memory/bus bridge.

## Interface
Parameters:
- `TIMEOUT`, 16: cycles allowed in REQ+WAIT before a fault; 0 disables the timeout.
- `NOP_INSTR`, 32'h00000013: instruction returned on any fault (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `fetch_en`  in  1  fetch request from the control unit, held high until `fetch_done`.
- `fetch_address`  in  32  byte address of the instruction.
- `fetch_done`  out  1  one-cycle pulse: `instruction`/`fetch_fault` valid.
- `instruction`  out  32  fetched word, held until the next `fetch_done`.
- `fetch_fault`  out  1  valid with `fetch_done`: 1 = misaligned or timeout.
- `fetch_busy`  out  1  high in every state except IDLE.
- `imem_req`  out  1  memory read request valid.
- `imem_addr`  out  32  word-aligned read address.
- `imem_ready`  in  1  memory accepts the request when `imem_req & imem_ready`.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE
  - `fetch_en` = 1 with `fetch_address[1:0]` == 0: capture the address into `imem_addr` and go to REQ.
  - `fetch_en` = 1 with `fetch_address[1:0]` != 0: load `instruction` = NOP_INSTR, set the fault flag, go to DONE. No memory access.
- REQ
  - `imem_req` = 1 and `imem_addr` stable.
  - On `imem_ready` = 1, go to WAIT.
- WAIT
  - On `imem_rvalid` = 1, load `instruction` = `imem_rdata`, clear the fault flag, go to DONE.
  - `imem_rvalid` is sampled only in WAIT and DRAIN and is ignored in all other states.
- Timeout
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the counter reaches TIMEOUT−1 without the exit condition, load NOP_INSTR and set the fault flag.
  - From REQ: go to DONE and drop `imem_req` (request aborted; the memory side tolerates a withdrawn request).
  - From WAIT: go to DONE, then DRAIN, because a response is still outstanding.
  - If a response or accept arrives on the same cycle as the timeout, the response or accept wins and no fault is raised.
- DONE
  - `fetch_done` = 1 and `fetch_fault` = the fault flag, for exactly one cycle.
  - Next state is DRAIN if the timeout occurred in WAIT, otherwise IDLE.
- DRAIN
  - Discard the first `imem_rvalid`, then go to IDLE.
  - `fetch_en` is ignored in DRAIN, so the stale word can never be returned as a later instruction.
- `fetch_en` is sampled only in IDLE. The control unit drops it after `fetch_done`. If it is still high in IDLE, a new fetch starts.
- `fetch_address` is captured once; later changes have no effect on an in-flight fetch.

## Timing
- Reset (`reset_n` = 0 at a rising edge), regardless of state:
  - State goes to IDLE.
  - `fetch_done`, `fetch_fault`, `fetch_busy` and `imem_req` = 0.
  - `imem_addr` and `instruction` = 0.
  - Counter and fault flag cleared.
  - Reset during WAIT does not drain; the memory is reset with the same `reset_n`.
- Zero-wait-state aligned fetch, with `fetch_en` sampled at edge 0:
  - `imem_req` high in cycle 1, accepted in cycle 1.
  - `imem_rvalid` in cycle 2.
  - `fetch_done` high in cycle 3.
  - Minimum latency is 3 cycles.
- Misaligned fetch: `fetch_done` high in cycle 1.
- `imem_req` asserts only in REQ. Once asserted it stays high with a stable address until accepted or timed out.
- Back-to-back fetches: the earliest next `imem_req` is 2 cycles after `fetch_done`.
- `fetch_busy` is registered and equals (state != IDLE).

## Test plan
- Aligned fetch, `fetch_address`=32'h0000_0100, `imem_ready`=1, `rdata`=32'h00A00093 in cycle 2 -> `imem_addr`=32'h100 in cycle 1; `fetch_done`=1 in cycle 3; `instruction`=32'h00A00093; `fetch_fault`=0.
- `imem_ready` low for 5 cycles, then response 3 cycles after accept -> `imem_req` held with a stable address; `fetch_done` exactly one cycle; no fault.
- `fetch_address`=32'h0000_0102 -> no `imem_req`; `fetch_done` in cycle 1 with `fault`=1 and `instruction`=32'h00000013.
- TIMEOUT=16, `imem_ready` accepts, no `rvalid` -> `fetch_done` with fault and NOP after 16 cycles in REQ+WAIT; unit enters DRAIN. A late `rvalid` (32'hDEADBEEF) is discarded. The next fetch returns its own data, never DEADBEEF.
- `rvalid` on the exact timeout cycle -> data returned, `fault`=0, no DRAIN.
- `reset_n` low for one cycle during WAIT -> all outputs 0 on the next cycle; the unit accepts a new `fetch_en` afterward.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read channel: valid/ready request plus separate response.
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Fetch unit side issues requests and consumes responses.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Memory / bus bridge side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: one memory read per fetch request, with local
// misalignment trap, bounded stall timeout and drain of orphaned responses.
module instruction_fetch_unit #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fetch_en,
  input  logic [31:0]             fetch_address,
  output logic                    fetch_done,
  output logic [31:0]             instruction,
  output logic                    fetch_fault,
  output logic                    fetch_busy,
  instruction_fetch_unit_if.master imem
);

  // Counter must hold TIMEOUT itself: an accept on the last REQ cycle moves
  // to WAIT with the count already past TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             fault_q;
  logic             fault_d;
  logic             drain_q;
  logic             drain_d;
  logic [31:0]      addr_d;
  logic [31:0]      instr_d;
  logic             aligned_c;
  logic             tmo_c;

  assign aligned_c = (fetch_address[1:0] == 2'b00);
  // Timeout fires at or past TIMEOUT-1; zero disables it entirely.
  assign tmo_c     = (TIMEOUT != 0) && (cnt_q >= CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; accept/response take priority over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_en) begin
          state_d = aligned_c ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (imem.imem_ready) begin
          state_d = S_WAIT;
        end else if (tmo_c) begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid || tmo_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = drain_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (imem.imem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: next values for address, instruction, flags, counter.
  always_comb begin
    cnt_d   = cnt_q;
    fault_d = fault_q;
    drain_d = drain_q;
    addr_d  = imem.imem_addr;
    instr_d = instruction;
    case (state_q)
      S_IDLE: begin
        if (fetch_en) begin
          if (aligned_c) begin
            addr_d = {fetch_address[31:2], 2'b00};
            cnt_d  = '0;
          end else begin
            instr_d = NOP_INSTR;
            fault_d = 1'b1;
            drain_d = 1'b0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!imem.imem_ready && tmo_c) begin
          instr_d = NOP_INSTR;
          fault_d = 1'b1;
          drain_d = 1'b0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          fault_d = 1'b0;
          drain_d = 1'b0;
        end else if (tmo_c) begin
          instr_d = NOP_INSTR;
          fault_d = 1'b1;
          drain_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (imem.imem_rvalid) begin
          drain_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      fault_q        <= 1'b0;
      drain_q        <= 1'b0;
      imem.imem_addr <= '0;
      imem.imem_req  <= 1'b0;
      instruction    <= '0;
      fetch_done     <= 1'b0;
      fetch_fault    <= 1'b0;
      fetch_busy     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      fault_q        <= fault_d;
      drain_q        <= drain_d;
      imem.imem_addr <= addr_d;
      imem.imem_req  <= (state_d == S_REQ);
      instruction    <= instr_d;
      fetch_done     <= (state_d == S_DONE);
      fetch_fault    <= (state_d == S_DONE) && fault_d;
      fetch_busy     <= (state_d != S_IDLE);
    end
  end

endmodule
